// File: rtl/switch_allocator.sv
// ============================================================================
// Module   : switch_allocator
// Purpose  : Wormhole switch allocator. One IDLE/LOCKED FSM per output with
//            round-robin selection. Optional per-output flit counters are
//            enabled by defining SWITCH_ALLOC_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int SEL_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0] req_port,
    input  logic [NUM_PORTS-1:0]           req_tail,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS*SEL_WIDTH-1:0] xbar_sel,
    output logic [NUM_PORTS-1:0]           xbar_valid,
    output logic                           req_err
`ifdef SWITCH_ALLOC_PERF_CNT_EN
    ,
    output logic [NUM_PORTS*16-1:0]        flit_cnt
`endif
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [SEL_WIDTH-1:0] w_port      [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_gnt_mat   [NUM_PORTS];
    logic [SEL_WIDTH-1:0] w_owner     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_locked;
    logic [NUM_PORTS-1:0] w_busy;
    logic [NUM_PORTS-1:0] w_bad;
    logic [NUM_PORTS-1:0] w_xv;
    logic                 r_req_err;

    // Cyclic index helper: v is always below 2*NUM_PORTS here.
    function automatic logic [SEL_WIDTH-1:0] f_wrap(input int v);
        return SEL_WIDTH'((v >= NUM_PORTS) ? (v - NUM_PORTS) : v);
    endfunction

    genvar gi;
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        assign w_port[gi] = req_port[gi*SEL_WIDTH +: SEL_WIDTH];
        assign w_bad[gi]  = req_valid[gi] && (int'(w_port[gi]) >= NUM_PORTS);
    end

    // An input already owning some output may not be picked by another one.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_locked[o] && (w_owner[o] == SEL_WIDTH'(i))) begin
                    w_busy[i] = 1'b1;
                end
            end
        end
    end

    genvar go;
    for (go = 0; go < NUM_PORTS; go++) begin : g_out
        logic [0:0]           r_state;
        logic [0:0]           w_state_nxt;
        logic [SEL_WIDTH-1:0] r_owner;
        logic [SEL_WIDTH-1:0] w_owner_nxt;
        logic [SEL_WIDTH-1:0] r_rr_ptr;
        logic [SEL_WIDTH-1:0] w_rr_nxt;
        logic [NUM_PORTS-1:0] w_req;
        logic                 w_found;
        logic                 w_xfer;

        always_comb begin
            w_req = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[i] = req_valid[i] && (w_port[i] == SEL_WIDTH'(go)) && !w_busy[i];
            end
        end

        assign w_xfer = (r_state == c_LOCKED) && req_valid[r_owner]
                        && (w_port[r_owner] == SEL_WIDTH'(go)) && out_ready[go];

        always_comb begin
            w_state_nxt = r_state;
            w_owner_nxt = r_owner;
            w_rr_nxt    = r_rr_ptr;
            w_found     = 1'b0;
            case (r_state)
                c_IDLE: begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (!w_found && w_req[f_wrap(int'(r_rr_ptr) + k)]) begin
                            w_found     = 1'b1;
                            w_owner_nxt = f_wrap(int'(r_rr_ptr) + k);
                            w_state_nxt = c_LOCKED;
                        end
                    end
                end
                c_LOCKED: begin
                    if (w_xfer && req_tail[r_owner]) begin
                        w_state_nxt = c_IDLE;
                        w_rr_nxt    = f_wrap(int'(r_owner) + 1);
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= c_IDLE;
                r_owner  <= '0;
                r_rr_ptr <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_owner  <= w_owner_nxt;
                r_rr_ptr <= w_rr_nxt;
            end
        end

        assign w_locked[go]  = (r_state == c_LOCKED);
        assign w_owner[go]   = r_owner;
        assign w_xv[go]      = w_xfer;
        assign w_gnt_mat[go] = w_xfer ? (NUM_PORTS'(1) << r_owner) : '0;
        assign xbar_sel[go*SEL_WIDTH +: SEL_WIDTH] = r_owner;
    end

    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant = grant | w_gnt_mat[o];
        end
    end

    assign xbar_valid = w_xv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_err <= 1'b0;
        end else if (|w_bad) begin
            r_req_err <= 1'b1;
        end
    end

    assign req_err = r_req_err;

`ifdef SWITCH_ALLOC_PERF_CNT_EN
    genvar gc;
    for (gc = 0; gc < NUM_PORTS; gc++) begin : g_cnt
        logic [15:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_xv[gc]) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign flit_cnt[gc*16 +: 16] = r_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 5, router port count; port index i equals the port_sel code i (0..4).
REQ-002 Parameter SEL_WIDTH, default 3, width of the port-select code.
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  [NUM_PORTS]  input port i holds a flit at its buffer head.
REQ-006 req_port  input  SEL_WIDTH x NUM_PORTS  requested output port for input i, from the routing unit's port_sel.
REQ-007 req_tail  input  [NUM_PORTS]  flit at input i is a tail flit; a single-flit packet has req_tail=1.
REQ-008 out_ready  input  [NUM_PORTS]  output port o can accept a flit this cycle (downstream credit available).
REQ-009 grant  output  [NUM_PORTS]  input i's head flit transfers this cycle; input pops its buffer.
REQ-010 xbar_sel  output  SEL_WIDTH x NUM_PORTS  input index driving crossbar output o.
REQ-011 xbar_valid  output  [NUM_PORTS]  crossbar output o carries a valid flit this cycle.
REQ-012 req_err  output  1  sticky flag: a valid request carried req_port >= NUM_PORTS.

Function
REQ-013 Each output o SHALL own a two-state FSM: IDLE, LOCKED, plus a registered owner index and a round-robin pointer rr_ptr.
REQ-014 An input i requests output o when req_valid[i]=1 and req_port[i]=o; requests with req_port >= NUM_PORTS SHALL be ignored and SHALL set req_err.
REQ-015 IDLE: if any input requests o, the first requester at or after rr_ptr (cyclic, wrapping at NUM_PORTS-1 -> 0) SHALL become owner and the FSM SHALL go LOCKED at the next edge; no grant is issued in the IDLE cycle (1-cycle arbitration latency).
REQ-016 An input SHALL NOT be chosen by output o while it is owner of, or locked to, any other output.
REQ-017 LOCKED: grant[owner]=1, xbar_valid[o]=1 and xbar_sel[o]=owner combinationally whenever req_valid[owner]=1, req_port[owner]=o and out_ready[o]=1; otherwise all three are 0 or hold, with xbar_sel stable.
REQ-018 A granted flit with req_tail=1 SHALL return the FSM to IDLE at that edge and set rr_ptr to (owner+1) mod NUM_PORTS.
REQ-019 While LOCKED, the lock SHALL persist through any number of cycles with req_valid[owner]=0 or out_ready[o]=0 (wormhole hold); other requesters wait.
REQ-020 At most one output SHALL grant a given input in any cycle; grant SHALL be the OR over outputs.
REQ-021 Outputs SHALL be independent: different outputs MAY lock and transfer in the same cycle.
REQ-022 rr_ptr SHALL change only on tail release; a lone requester SHALL win regardless of rr_ptr.

Reset
REQ-023 rst_n low SHALL immediately force all FSMs to IDLE, owners and rr_ptr to 0, req_err to 0; grant, xbar_valid, xbar_sel SHALL read 0.
REQ-024 Reset mid-packet SHALL drop all locks; after release, arbitration restarts from rr_ptr=0 with no grant in the first cycle.

Configuration
REQ-025 Macro SWITCH_ALLOC_PERF_CNT_EN: when defined, the block SHALL add output flit_cnt (16 x NUM_PORTS), per-output count of granted flits, incrementing on each grant, wrapping 0xFFFF -> 0x0000, reset to 0.
REQ-026 Without SWITCH_ALLOC_PERF_CNT_EN the port and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-027 Inputs 1,2,3 each send a 1-flit packet (tail=1) to output 0, out_ready=1 -> grants to 1,2,3 on cycles 2,4,6 after reset release, rr_ptr ends at 4.
REQ-028 Input 2 sends a 4-flit packet to output 4, input 0 requests output 4 from cycle 1 -> input 0 gets no grant until the edge after input 2's tail is granted.
REQ-029 Locked owner drops req_valid for 3 cycles mid-packet -> lock held, xbar_valid[o]=0 for those 3 cycles, no other grant to o.
REQ-030 Inputs 0->1 and 3->4 simultaneously, out_ready all 1 -> both outputs lock and transfer in the same cycles; grant=5'b01001.
REQ-031 req_port=5 with req_valid=1 -> no grant, req_err=1 and stays 1 until rst_n low.
REQ-032 rst_n pulsed low during a locked 3-flit packet -> grant/xbar_valid 0 during reset; with PERF_CNT_EN, flit_cnt reads 0 afterward.
